misapp_expr_sequencer: RTL and testbench
========================================

MISAPP_EXPR_SEQUENCER -- requirements
Module: misapp_expr_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SURPRISE_CODE  8'd4  expression code treated as "surprised"
  CONFIRM_FRAMES  3  consecutive surprised frames needed to confirm misapplication (1..15)
  WINDOW_CYCLES  1000  clock cycles after an accel spike during which confirmation counts (2..65535)
  HOLD_CYCLES  5000  clock cycles misapp_alert stays asserted (1..65535)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on its rising edge
  rst_n  in  1  asynchronous active-low reset
  expr_valid  in  1  expression frame available
  expr_code  in  8  expression class code, sampled when expr_valid and expr_ready are both 1
  expr_ready  out  1  sequencer accepts a frame this cycle
  accel_spike  in  1  single-cycle pulse: abrupt accelerator-pedal press
  alert_clear  in  1  driver/ECU acknowledge; ends ALERT early
  misapp_alert  out  1  pedal-misapplication alert, registered
  seq_state  out  2  current state: 0 IDLE, 1 ARMED, 2 ALERT
  alert_count  out  8  number of ALERT entries since reset, saturating at 255

Function
REQ-003 The block SHALL be a 3-state FSM: IDLE, ARMED, ALERT; encoding per REQ-002 seq_state; value 3 unreachable and SHALL decode to IDLE next cycle.
REQ-004 A frame SHALL be accepted only in a cycle with expr_valid=1 and expr_ready=1; expr_ready SHALL be 1 in IDLE and ARMED, 0 in ALERT (combinational from state).
REQ-005 Frames accepted in IDLE SHALL be discarded with no effect.
REQ-006 IDLE: accel_spike=1 -> ARMED next cycle; window counter loaded with WINDOW_CYCLES-1; surprise counter cleared.
REQ-007 ARMED, accepted frame: expr_code==SURPRISE_CODE increments the surprise counter; any other code clears it to 0.
REQ-008 ARMED: when an accepted surprised frame makes the counter equal CONFIRM_FRAMES -> ALERT next cycle; hold counter loaded with HOLD_CYCLES-1; alert_count +1 unless already 255.
REQ-009 ARMED: window counter decrements each cycle; when it is 0 and no confirmation occurs that cycle -> IDLE, surprise counter cleared.
REQ-010 ARMED, simultaneous events: confirmation SHALL win over window expiry; accel_spike without confirmation reloads the window counter to WINDOW_CYCLES-1 and keeps the surprise counter.
REQ-011 ALERT: misapp_alert=1; hold counter decrements each cycle; at 0 -> IDLE; alert_clear=1 -> IDLE next cycle regardless of hold counter.
REQ-012 ALERT: accel_spike and expr_valid SHALL be ignored; on exit, surprise counter SHALL be 0.
REQ-013 misapp_alert SHALL be a register equal to (state==ALERT): rises the cycle after the confirming frame is accepted, falls the cycle after exit.
REQ-014 Counter widths: surprise 4 bits, window 16 bits, hold 16 bits; no counter SHALL wrap below 0.

Reset
REQ-015 On rst_n low, asynchronously: state IDLE, misapp_alert 0, alert_count 0, all counters 0; expr_ready follows IDLE (1).
REQ-016 Reset asserted mid-ARMED or mid-ALERT SHALL abort immediately with no residual alert; first cycle after release behaves as IDLE.

Verification (bench params CONFIRM_FRAMES=3, WINDOW_CYCLES=8, HOLD_CYCLES=4)
REQ-017 Spike, then frames 4,4,4 on consecutive cycles -> ALERT, misapp_alert=1 one cycle after third frame, held 4 cycles, then IDLE; alert_count=1.
REQ-018 Spike, frames 4,4,2,4 -> counter resets on 2; no alert; window expires after 8 cycles -> IDLE, misapp_alert stays 0.
REQ-019 Spike, third surprised frame accepted on the expiry cycle (window=0) -> ALERT (confirmation wins).
REQ-020 In ALERT, expr_valid=1 -> expr_ready=0, no acceptance; alert_clear pulse on hold cycle 2 -> IDLE next cycle, misapp_alert=0.
REQ-021 Surprised frames in IDLE with no spike -> no state change; rst_n low during ALERT -> misapp_alert=0, seq_state=0 immediately.
REQ-022 256 forced alerts -> alert_count saturates at 255.

Source files
------------

// File: rtl/misapp_expr_sequencer.sv
// Pedal-misapplication sequencer: an accelerator spike arms a confirmation
// window; enough consecutive "surprised" expression frames inside that
// window raise a timed alert.
//
// state | meaning
// IDLE  | waiting for an accelerator spike; accepted frames are dropped
// ARMED | window running, counting consecutive surprised frames
// ALERT | misapp_alert asserted until hold expiry or alert_clear
module misapp_expr_sequencer #(
  parameter logic [7:0]  SURPRISE_CODE  = 8'd4,
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned WINDOW_CYCLES  = 1000,
  parameter int unsigned HOLD_CYCLES    = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       expr_valid,
  input  logic [7:0] expr_code,
  output logic       expr_ready,
  input  logic       accel_spike,
  input  logic       alert_clear,
  output logic       misapp_alert,
  output logic [1:0] seq_state,
  output logic [7:0] alert_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  localparam logic [3:0]  CONFIRM_N = 4'(CONFIRM_FRAMES);
  localparam logic [15:0] WIN_LOAD  = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  surp_q, surp_d;
  logic [15:0] win_q, win_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        alert_q;

  logic        accept;
  logic        surprised;
  logic [3:0]  surp_inc;
  logic [3:0]  surp_next;
  logic        confirm;

  assign expr_ready   = (state_q != S_ALERT);
  assign seq_state    = state_q;
  assign misapp_alert = alert_q;
  assign alert_count  = cnt_q;

  // Frame acceptance and the streak value an accepted frame would produce.
  always_comb begin
    accept    = expr_valid & expr_ready;
    surprised = accept && (expr_code == SURPRISE_CODE);
    surp_inc  = (surp_q == 4'hF) ? surp_q : surp_q + 4'd1;
    surp_next = surp_q;
    if (surprised) begin
      surp_next = surp_inc;
    end else if (accept) begin
      surp_next = 4'd0;
    end
    confirm = (state_q == S_ARMED) && surprised && (surp_inc == CONFIRM_N);
  end

  // Next-state and counter updates; confirmation has priority over a spike
  // reload, which has priority over window expiry.
  always_comb begin
    state_d = state_q;
    surp_d  = surp_q;
    win_d   = win_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accel_spike) begin
          state_d = S_ARMED;
          win_d   = WIN_LOAD;
          surp_d  = 4'd0;
        end
      end
      S_ARMED: begin
        if (confirm) begin
          state_d = S_ALERT;
          hold_d  = HOLD_LOAD;
          surp_d  = 4'd0;
          win_d   = 16'd0;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (accel_spike) begin
          win_d  = WIN_LOAD;
          surp_d = surp_next;
        end else if (win_q == 16'd0) begin
          state_d = S_IDLE;
          surp_d  = 4'd0;
        end else begin
          win_d  = win_q - 16'd1;
          surp_d = surp_next;
        end
      end
      S_ALERT: begin
        surp_d = 4'd0;
        if (alert_clear || (hold_q == 16'd0)) begin
          state_d = S_IDLE;
          hold_d  = 16'd0;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        surp_d  = 4'd0;
        win_d   = 16'd0;
        hold_d  = 16'd0;
      end
    endcase
  end

  // State, counters and the registered alert output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      surp_q  <= 4'd0;
      win_q   <= 16'd0;
      hold_q  <= 16'd0;
      cnt_q   <= 8'd0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      surp_q  <= surp_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      alert_q <= (state_d == S_ALERT);
    end
  end

endmodule

// File: tb/tb_misapp_expr_sequencer.sv
// Bench for misapp_expr_sequencer: directed scenarios plus random traffic,
// checked by a scoreboard fed from an absolute-cycle reference model.
module tb_misapp_expr_sequencer;

  localparam int SUR  = 4;
  localparam int CONF = 3;
  localparam int WIN  = 8;
  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       expr_valid = 1'b0;
  logic [7:0] expr_code = 8'd0;
  logic       expr_ready;
  logic       accel_spike = 1'b0;
  logic       alert_clear = 1'b0;
  logic       misapp_alert;
  logic [1:0] seq_state;
  logic [7:0] alert_count;

  int total = 0;
  int bad = 0;

  typedef struct {
    int mode;
    int alert;
    int count;
  } exp_t;

  exp_t sb[$];

  // Reference model: modes plus absolute cycle numbers for the deadlines.
  int cyc;
  int m_mode;
  int m_last_armed;
  int m_alert_end;
  int m_streak;
  int m_count;

  misapp_expr_sequencer #(
    .SURPRISE_CODE(8'd4),
    .CONFIRM_FRAMES(CONF),
    .WINDOW_CYCLES(WIN),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .expr_valid(expr_valid),
    .expr_code(expr_code),
    .expr_ready(expr_ready),
    .accel_spike(accel_spike),
    .alert_clear(alert_clear),
    .misapp_alert(misapp_alert),
    .seq_state(seq_state),
    .alert_count(alert_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cyc = 0;
    m_mode = 0;
    m_last_armed = 0;
    m_alert_end = 0;
    m_streak = 0;
    m_count = 0;
  endfunction

  // Drive one cycle of inputs (called at a negedge) and predict the outputs
  // that appear after the following rising edge.
  task automatic step(input bit v, input int code, input bit spike, input bit clr);
    exp_t e;
    expr_valid  = v;
    expr_code   = 8'(code);
    accel_spike = spike;
    alert_clear = clr;
    #1;
    chk("expr_ready", int'(expr_ready), (m_mode != 2) ? 1 : 0);
    case (m_mode)
      0: begin
        if (spike) begin
          m_mode = 1;
          m_last_armed = cyc + WIN;
          m_streak = 0;
        end
      end
      1: begin
        if (v) m_streak = (code == SUR) ? m_streak + 1 : 0;
        if (m_streak == CONF) begin
          m_mode = 2;
          m_alert_end = cyc + HOLD;
          m_streak = 0;
          if (m_count < 255) m_count++;
        end else if (spike) begin
          m_last_armed = cyc + WIN;
        end else if (cyc == m_last_armed) begin
          m_mode = 0;
          m_streak = 0;
        end
      end
      default: begin
        if (clr || cyc == m_alert_end) m_mode = 0;
      end
    endcase
    cyc++;
    e.mode = m_mode;
    e.alert = (m_mode == 2) ? 1 : 0;
    e.count = m_count;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst seq_state", int'(seq_state), 0);
    chk("rst misapp_alert", int'(misapp_alert), 0);
    chk("rst alert_count", int'(alert_count), 0);
    chk("rst expr_ready", int'(expr_ready), 1);
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle out of reset the DUT presents its state; compare
  // against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (int'(seq_state) != e.mode || int'(misapp_alert) != e.alert ||
            int'(alert_count) != e.count) begin
          bad++;
          $display("FAIL scoreboard: got state=%0d alert=%0d count=%0d expected state=%0d alert=%0d count=%0d (t=%0t)",
                   seq_state, misapp_alert, alert_count, e.mode, e.alert, e.count, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("por seq_state", int'(seq_state), 0);
    chk("por misapp_alert", int'(misapp_alert), 0);
    chk("por alert_count", int'(alert_count), 0);
    chk("por expr_ready", int'(expr_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Confirmed alert: spike then three surprised frames back to back.
    step(0, 0, 1, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    idle(6);
    chk("first alert_count", int'(alert_count), 1);

    // Broken streak, then window expiry.
    step(0, 0, 1, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 2, 0, 0);
    step(1, 4, 0, 0);
    idle(8);

    // Third surprised frame lands on the expiry cycle.
    step(0, 0, 1, 0);
    idle(5);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    idle(6);

    // Frames refused during ALERT, early clear on hold cycle 2.
    step(0, 0, 1, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 1, 0);
    step(1, 4, 0, 1);
    idle(3);

    // Surprised frames with no spike are ignored; then reset during ALERT.
    for (int i = 0; i < 5; i++) step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(1, 4, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    idle(2);

    // Random traffic, biased toward surprised frames.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? SUR : int'($urandom_range(0, 255)),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 7) == 0));
    end
    idle(12);

    // Drive 256 alerts from a clean count to reach saturation.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 0);
      step(1, 4, 0, 0);
      step(1, 4, 0, 0);
      step(1, 4, 0, 0);
      step(0, 0, 0, 1);
    end
    idle(2);
    chk("saturated alert_count", int'(alert_count), 255);

    @(posedge clk);
    #2;
    chk("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
